// File: rtl/lab5_pkg.sv
// Shared definitions for the Lab 5 divider.
// div_state_t : control states of the restoring divider (kept distinct from
//               the multiplier's global state type).
// ITER        : number of shift/subtract iterations for an 8-bit operand.
package lab5_pkg;

    typedef enum logic [2:0] {
        reset,
        ready,
        loadQ,
        loadD,
        shift,
        sub,
        done
    } div_state_t;

    localparam logic [3:0] ITER = 4'd8;

endpackage

// File: rtl/divider_8bit_if.sv
// Board-side signal bundle for the divider.
//   LoadQ, Run : active-low pushbuttons
//   S          : 8-bit switch operand
//   Aval, Qval : remainder / dividend-then-quotient registers
//   Busy, Done : status (loadD/shift/sub, done)
//   DivZero    : divisor was zero in the last loadD
//   AhexU/L, QhexU/L : seven-segment digits of A and Q
interface divider_8bit_if;

    logic       LoadQ;
    logic       Run;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Qval;
    logic       Busy;
    logic       Done;
    logic       DivZero;
    logic [6:0] AhexU;
    logic [6:0] AhexL;
    logic [6:0] QhexU;
    logic [6:0] QhexL;

    // Board / stimulus side drives buttons and switches.
    modport master (
        output LoadQ, Run, S,
        input  Aval, Qval, Busy, Done, DivZero,
        input  AhexU, AhexL, QhexU, QhexL
    );

    // Divider side.
    modport slave (
        input  LoadQ, Run, S,
        output Aval, Qval, Busy, Done, DivZero,
        output AhexU, AhexL, QhexU, QhexL
    );

endinterface

// File: rtl/divider_8bit_state_selector.sv
// Next-state logic of the divider control FSM (purely combinational).
//   Reset      : synchronous active-low reset request
//   LoadQ, Run : active-low buttons
//   count_done : iteration counter has reached ITER
//   cur_state  : current state
//   next_state : state to enter on the next rising edge
module div_state_selector
    import lab5_pkg::*;
(
    input  logic       Reset,
    input  logic       LoadQ,
    input  logic       Run,
    input  logic       count_done,
    input  div_state_t cur_state,
    output div_state_t next_state
);

    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred for unlisted states.
        next_state = cur_state;
        if (!Reset) begin
            next_state = reset;
        end else begin
            case (cur_state)
                reset: next_state = ready;
                // Run is checked first so it wins when both buttons are down.
                ready: begin
                    if (!Run)
                        next_state = loadD;
                    else if (!LoadQ)
                        next_state = loadQ;
                end
                loadQ: next_state = ready;
                loadD: next_state = shift;
                shift: next_state = sub;
                sub:   next_state = count_done ? done : shift;
                // Wait for Run to be released so a held button cannot
                // start a second division.
                done:  next_state = Run ? ready : done;
                default: next_state = reset;
            endcase
        end
    end

endmodule

// File: rtl/hex_driver.sv
// Seven-segment decoder for one byte (two digits), active-low segments
// ordered {g,f,e,d,c,b,a}.
//   In0  : byte to display
//   OutU : digit for In0[7:4]
//   OutL : digit for In0[3:0]
module HexDriver (
    input  logic [7:0] In0,
    output logic [6:0] OutU,
    output logic [6:0] OutL
);

    function automatic logic [6:0] seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b1111111;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign OutU = seg(In0[7:4]);
    assign OutL = seg(In0[3:0]);

endmodule

// File: rtl/divider_8bit.sv
// Sequential 8-bit unsigned restoring divider.
// Load the dividend with LoadQ, then press Run with the divisor on S.
// After 17 cycles Q holds the quotient and A the remainder.
//   Clk   : rising-edge clock
//   Reset : synchronous active-low reset (forces the reset state)
//   bus   : buttons, switches, register views, status and hex digits
module divider_8bit
    import lab5_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    divider_8bit_if.slave  bus
);

    div_state_t state;
    div_state_t next_state;

    logic [7:0] a;
    logic [7:0] q;
    logic [7:0] d;
    logic [3:0] c;
    logic       e;          // bit shifted out of A; P = {e, a} during sub
    logic       div_zero;
    logic       busy_r;
    logic       done_r;

    // Restoring step: subtract only if the 9-bit partial remainder P is at
    // least D. The 8-bit difference equals the low byte of the 10-bit T.
    logic       t_neg;
    logic [7:0] t_low;

    assign t_neg = ({e, a} < {1'b0, d});
    assign t_low = a - d;

    div_state_selector u_sel (
        .Reset      (Reset),
        .LoadQ      (bus.LoadQ),
        .Run        (bus.Run),
        .count_done (c == ITER),
        .cur_state  (state),
        .next_state (next_state)
    );

    always_ff @(posedge Clk) begin
        // NOTE: every register here is assigned with <= so all of them
        // update from the same pre-edge values.
        state <= next_state;

        // Status is registered from next_state so it lines up with state.
        busy_r <= (next_state inside {loadD, shift, sub});
        done_r <= (next_state == done);

        case (state)
            reset: begin
                a        <= '0;
                q        <= '0;
                d        <= '0;
                c        <= '0;
                e        <= 1'b0;
                div_zero <= 1'b0;
            end
            loadQ: begin
                q <= bus.S;
                a <= '0;
            end
            loadD: begin
                d        <= bus.S;
                a        <= '0;
                c        <= '0;
                div_zero <= (bus.S == 8'd0);
            end
            shift: begin
                e <= a[7];
                a <= {a[6:0], q[7]};
                q <= {q[6:0], 1'b0};
                c <= c + 4'd1;
            end
            sub: begin
                // On a negative trial result A already holds P[7:0].
                if (!t_neg) begin
                    a    <= t_low;
                    q[0] <= 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.Aval    = a;
    assign bus.Qval    = q;
    assign bus.Busy    = busy_r;
    assign bus.Done    = done_r;
    assign bus.DivZero = div_zero;

    HexDriver u_hex_a (
        .In0  (a),
        .OutU (bus.AhexU),
        .OutL (bus.AhexL)
    );

    HexDriver u_hex_q (
        .In0  (q),
        .OutU (bus.QhexU),
        .OutL (bus.QhexL)
    );

endmodule

// File: tb/tb_divider_8bit.sv
// Directed testbench for divider_8bit.
module tb_divider_8bit;
    import lab5_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    divider_8bit_if bus ();

    divider_8bit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG2 = 7'b0100100;
    localparam logic [6:0] SEGE = 7'b0000110;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_q(input logic [7:0] v);
        bus.S     = v;
        bus.LoadQ = 1'b0;
        @(negedge Clk);
        bus.LoadQ = 1'b1;
        @(negedge Clk);
    endtask

    // Press Run with divisor dv and wait (bounded) for Done.
    // lat is the number of edges after edge 0; -1 on timeout.
    task automatic divide(input logic [7:0] dv, output int lat, output int busy_cycles);
        bus.S       = dv;
        bus.Run     = 1'b0;
        lat         = -1;
        busy_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (bus.Busy) busy_cycles++;
            if (bus.Done) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic run_case(input string pfx, input logic [7:0] dividend, input logic [7:0] divisor,
                            input logic [7:0] exp_q, input logic [7:0] exp_a, input logic exp_dz);
        int lat;
        int bc;
        load_q(dividend);
        check({pfx, "_loadq"}, 32'(bus.Qval), 32'(dividend));
        divide(divisor, lat, bc);
        check({pfx, "_latency"}, 32'(lat), 32'd17);
        check({pfx, "_busy_cycles"}, 32'(bc), 32'd17);
        check({pfx, "_done"}, 32'(bus.Done), 32'd1);
        check({pfx, "_busy_end"}, 32'(bus.Busy), 32'd0);
        check({pfx, "_q"}, 32'(bus.Qval), 32'(exp_q));
        check({pfx, "_a"}, 32'(bus.Aval), 32'(exp_a));
        check({pfx, "_divzero"}, 32'(bus.DivZero), 32'(exp_dz));
        bus.Run = 1'b1;
        @(negedge Clk);
        check({pfx, "_release"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int rises;
        int lat;
        int bc;
        logic prev_done;

        // Reset: two edges with Reset low, then release.
        Reset     = 1'b0;
        bus.LoadQ = 1'b1;
        bus.Run   = 1'b1;
        bus.S     = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_a", 32'(bus.Aval), 32'h0);
        check("rst_q", 32'(bus.Qval), 32'h0);
        check("rst_busy", 32'(bus.Busy), 32'h0);
        check("rst_done", 32'(bus.Done), 32'h0);
        check("rst_divzero", 32'(bus.DivZero), 32'h0);
        check("rst_hex", {4'h0, bus.AhexU, bus.AhexL, bus.QhexU, bus.QhexL},
              {4'h0, SEG0, SEG0, SEG0, SEG0});
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_ready", 32'(dut.state), 32'(ready));

        // 100 / 7 = 14 r 2, plus hex view of the result.
        load_q(8'd100);
        check("d100_loadq", 32'(bus.Qval), 32'h64);
        divide(8'd7, lat, bc);
        check("d100_latency", 32'(lat), 32'd17);
        check("d100_q", 32'(bus.Qval), 32'h0E);
        check("d100_a", 32'(bus.Aval), 32'h02);
        check("d100_divzero", 32'(bus.DivZero), 32'h0);
        check("d100_hex", {4'h0, bus.AhexU, bus.AhexL, bus.QhexU, bus.QhexL},
              {4'h0, SEG0, SEG2, SEG0, SEGE});
        bus.Run = 1'b1;
        @(negedge Clk);
        check("d100_ready", 32'(dut.state), 32'(ready));

        // Boundary quotients.
        run_case("q255_d1", 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0);
        run_case("q5_d9",   8'd5,   8'd9, 8'h00, 8'h05, 1'b0);
        // Divide by zero, then a normal division clears the flag.
        run_case("q200_d0", 8'd200, 8'd0, 8'hFF, 8'hC8, 1'b1);
        run_case("q200_d3", 8'd200, 8'd3, 8'h42, 8'h02, 1'b0);

        // Run held low for 40 cycles: exactly one division.
        load_q(8'd100);
        bus.S     = 8'd7;
        bus.Run   = 1'b0;
        busy_cnt  = 0;
        rises     = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Busy) busy_cnt++;
            if (bus.Done && !prev_done) rises++;
            prev_done = bus.Done;
        end
        check("hold_busy_cycles", 32'(busy_cnt), 32'd17);
        check("hold_done_rises", 32'(rises), 32'd1);
        check("hold_still_done", 32'(bus.Done), 32'd1);
        check("hold_q", 32'(bus.Qval), 32'h0E);
        bus.Run = 1'b1;
        @(negedge Clk);
        check("hold_release_done", 32'(bus.Done), 32'd0);
        check("hold_release_state", 32'(dut.state), 32'(ready));

        // Reset in the middle of a division.
        load_q(8'd100);
        bus.S   = 8'd7;
        bus.Run = 1'b0;
        repeat (6) @(negedge Clk);
        check("mid_busy_before", 32'(bus.Busy), 32'd1);
        Reset   = 1'b0;
        bus.Run = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_a", 32'(bus.Aval), 32'h0);
        check("mid_q", 32'(bus.Qval), 32'h0);
        check("mid_busy", 32'(bus.Busy), 32'h0);
        check("mid_done", 32'(bus.Done), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        check("mid_ready", 32'(dut.state), 32'(ready));

        // Both buttons pressed in ready: Run wins.
        bus.S     = 8'h55;
        bus.LoadQ = 1'b0;
        bus.Run   = 1'b0;
        @(negedge Clk);
        check("both_state", 32'(dut.state), 32'(loadD));
        check("both_busy", 32'(bus.Busy), 32'd1);
        bus.LoadQ = 1'b1;
        bc = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.Done) break;
            @(negedge Clk);
            bc++;
        end
        check("both_done", 32'(bus.Done), 32'd1);
        check("both_q", 32'(bus.Qval), 32'h00);
        check("both_a", 32'(bus.Aval), 32'h00);
        bus.Run = 1'b1;
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
